// File: rtl/uart_pkg.sv
// Shared FSM state type, parity-mode constants and frame helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        ARM    = 3'd5
    } rx_state_e;

    localparam int PAR_NONE = 32'sd0;
    localparam int PAR_ODD  = 32'sd1;
    localparam int PAR_EVEN = 32'sd2;

    function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
        return 32'sd1 + data_bits + ((parity_mode != PAR_NONE) ? 32'sd1 : 32'sd0) + stop_bits;
    endfunction

    // acc is the XOR of all data bits and the received parity bit
    function automatic logic parity_error(input int parity_mode, input logic acc);
        case (parity_mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the raw RX pin. With RX_MAJORITY_EN defined, each sample is a
// registered 2-of-3 vote and the line view is delayed one cycle so both stay aligned.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rx,
    output logic line_s,
    output logic bit_s
);

    logic sync1_r;
    logic rxs_r;

    // Metastability synchroniser, resets to the idle-high line level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx;
            rxs_r   <= sync1_r;
        end
    end

`ifdef RX_MAJORITY_EN
    logic line_r;
    logic vote_r;

    // sync1_r is rxs one cycle early, so the vote is centred on the delayed line_r
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_r <= 1'b1;
            vote_r <= 1'b1;
        end else begin
            line_r <= rxs_r;
            vote_r <= majority3(sync1_r, rxs_r, line_r);
        end
    end

    assign line_s = line_r;
    assign bit_s  = vote_r;
`else
    assign line_s = rxs_r;
    assign bit_s  = rxs_r;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised asynchronous-serial receiver with a one-deep ready/valid holding register.
// Optional macro RX_MAJORITY_EN: 2-of-3 majority sampling, shifting all timing by one cycle.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int              TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   BIT_LOAD   = TW'(CLKS_PER_BIT - 32'sd1);
    localparam logic [TW-1:0]   HALF_LOAD  = TW'(CLKS_PER_BIT / 32'sd2 - 32'sd1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(32'sd1);
    localparam logic [TW-1:0]   TIMER_ZERO = TW'(32'sd0);
    localparam logic [3:0]      LAST_DATA  = 4'(DATA_BITS - 32'sd1);
    localparam logic [3:0]      LAST_BIT   = 4'(frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS) - 32'sd2);
    localparam bit              HAS_PARITY = (PARITY_MODE != PAR_NONE);

    logic                 line_s;
    logic                 bit_s;
    logic                 tick_s;
    logic                 hold_free_s;
    logic                 frame_err_s;
    logic                 parity_err_s;
    rx_state_e            state_r;
    logic [TW-1:0]        timer_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_acc_r;
    logic                 stop_bad_r;

    uart_rx_sampler u_sampler (
        .clock  (clock),
        .reset  (reset),
        .rx     (rx),
        .line_s (line_s),
        .bit_s  (bit_s)
    );

    assign tick_s       = (timer_r == TIMER_ZERO);
    assign hold_free_s  = !rx_valid || rx_ready;
    assign frame_err_s  = stop_bad_r | ~bit_s;
    assign parity_err_s = parity_error(PARITY_MODE, par_acc_r);

    // Frame FSM with bit timer, shift register and output holding register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            timer_r     <= TIMER_ZERO;
            bit_cnt_r   <= 4'd0;
            shift_r     <= {DATA_BITS{1'b0}};
            par_acc_r   <= 1'b0;
            stop_bad_r  <= 1'b0;
            rx_data     <= {DATA_BITS{1'b0}};
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (!line_s) begin
                        state_r <= START;
                        timer_r <= HALF_LOAD;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (!tick_s) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else if (bit_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r    <= DATA;
                        timer_r    <= BIT_LOAD;
                        bit_cnt_r  <= 4'd0;
                        par_acc_r  <= 1'b0;
                        stop_bad_r <= 1'b0;
                    end
                end
                DATA: begin
                    if (!tick_s) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else begin
                        shift_r   <= {bit_s, shift_r[DATA_BITS-1:1]};
                        par_acc_r <= par_acc_r ^ bit_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        timer_r   <= BIT_LOAD;
                        if (bit_cnt_r == LAST_DATA) begin
                            state_r <= HAS_PARITY ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (!tick_s) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else begin
                        par_acc_r <= par_acc_r ^ bit_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        timer_r   <= BIT_LOAD;
                        state_r   <= STOP;
                    end
                end
                STOP: begin
                    if (!tick_s) begin
                        timer_r <= timer_r - TIMER_ONE;
                    end else if (bit_cnt_r != LAST_BIT) begin
                        stop_bad_r <= stop_bad_r | ~bit_s;
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                        timer_r    <= BIT_LOAD;
                    end else begin
                        // Last stop sample: hand the frame over, or drop it if the holder is still full
                        state_r <= ARM;
                        if (hold_free_s) begin
                            rx_data    <= shift_r;
                            rx_valid   <= 1'b1;
                            frame_err  <= frame_err_s;
                            parity_err <= parity_err_s;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (line_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 7E1 and 8N2 instances, directed frames,
// expected words queued at stimulus time and checked by a monitor on each accepted word.
module tb_uart_rx_param;

    localparam int CPB = 10;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       fe;
        logic       pe;
        int         t_raw;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] rx_l;
    logic [2:0] rdy;
    logic [2:0] vld;
    logic [2:0] fe;
    logic [2:0] pe;
    logic [2:0] ovr;
    logic [2:0] bsy;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [8:0] md [3];
    int         cyc = 0;
    int         n_cmp;
    int         n_bad;
    int         ovr_cnt [3];
    exp_t       exp_q [$];
    exp_t       mon_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign md[0] = {1'b0, d0};
    assign md[1] = {2'b00, d1};
    assign md[2] = {1'b0, d2};

    uart_rx_param #(.CLKS_PER_BIT(CPB)) u_8n1 (
        .clock(clock), .reset(reset), .rx(rx_l[0]), .rx_data(d0), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun_err(ovr[0]), .busy(bsy[0])
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2)) u_7e1 (
        .clock(clock), .reset(reset), .rx(rx_l[1]), .rx_data(d1), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun_err(ovr[1]), .busy(bsy[1])
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_8n2 (
        .clock(clock), .reset(reset), .rx(rx_l[2]), .rx_data(d2), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun_err(ovr[2]), .busy(bsy[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input logic [8:0] data, input logic efe, input logic epe, input int t_raw);
        exp_t e;
        e.inst  = inst;
        e.data  = data;
        e.fe    = efe;
        e.pe    = epe;
        e.t_raw = t_raw;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input int inst, input logic b);
        rx_l[inst] = b;
        repeat (CPB) @(negedge clock);
    endtask

    // One frame starting at the next falling clock edge, then two idle bit times
    task automatic send(input int inst, input logic [8:0] data, input int nbits, input bit par_en,
                        input logic pbit, input int nstop, input logic last_stop);
        @(negedge clock);
        drive_bit(inst, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(inst, data[i]);
        if (par_en) drive_bit(inst, pbit);
        for (int s = 0; s < nstop; s++) drive_bit(inst, (s == nstop - 1) ? last_stop : 1'b1);
        rx_l[inst] = 1'b1;
        repeat (2 * CPB) @(negedge clock);
    endtask

    task automatic set_ready(input int inst, input logic v);
        @(posedge clock);
        #1;
        rdy[inst] = v;
    endtask

    initial begin
        reset   = 1'b0;
        rx_l    = 3'b111;
        rdy     = 3'b111;
        n_cmp   = 0;
        n_bad   = 0;
        for (int k = 0; k < 3; k++) ovr_cnt[k] = 0;

        fork
            forever begin
                @(negedge clock);
                for (int k = 0; k < 3; k++) begin
                    if (ovr[k]) ovr_cnt[k]++;
                    if (vld[k] && rdy[k]) begin
                        if (exp_q.size() == 0 || exp_q[0].inst != k) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_word inst %0d: got 0x%0h, expected none", k, md[k]);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check("word_data", 32'(md[k]), 32'(mon_e.data));
                            check("word_frame_err", 32'(fe[k]), 32'(mon_e.fe));
                            check("word_parity_err", 32'(pe[k]), 32'(mon_e.pe));
                            if (mon_e.t_raw >= 0) check("valid_latency", 32'(cyc - mon_e.t_raw), 32'd98);
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            check("reset_valid", 32'(vld[k]), 32'd0);
            check("reset_busy", 32'(bsy[k]), 32'd0);
            check("reset_data", 32'(md[k]), 32'd0);
        end
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // 8N1 0xA5, latency from the raw falling edge
        push(0, 9'h0A5, 1'b0, 1'b0, cyc + 1);
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);

        // Three-cycle glitch is a false start, then a clean 0x3C
        rx_l[0] = 1'b0;
        repeat (3) @(negedge clock);
        check("glitch_busy_high", 32'(bsy[0]), 32'd1);
        rx_l[0] = 1'b1;
        repeat (12) @(negedge clock);
        check("glitch_busy_low", 32'(bsy[0]), 32'd0);
        push(0, 9'h03C, 1'b0, 1'b0, -1);
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);

        // 7E1 0x55: parity bit 1 is wrong, 0 is right
        push(1, 9'h055, 1'b0, 1'b1, -1);
        send(1, 9'h055, 7, 1'b1, 1'b1, 1, 1'b1);
        push(1, 9'h055, 1'b0, 1'b0, -1);
        send(1, 9'h055, 7, 1'b1, 1'b0, 1, 1'b1);

        // 8N2 0x81 with the second stop bit low
        push(2, 9'h081, 1'b1, 1'b0, -1);
        send(2, 9'h081, 8, 1'b0, 1'b0, 2, 1'b0);

        // Overrun: 0x22 dropped while 0x11 is held
        set_ready(0, 1'b0);
        ovr_cnt[0] = 0;
        push(0, 9'h011, 1'b0, 1'b0, -1);
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        check("overrun_pulses", 32'(ovr_cnt[0]), 32'd1);
        check("held_data", 32'(md[0]), 32'h11);
        check("held_valid", 32'(vld[0]), 32'd1);
        set_ready(0, 1'b1);
        repeat (5) @(negedge clock);
        check("valid_after_accept", 32'(vld[0]), 32'd0);

        // Break for three frame times, then a clean 0x7E
        push(0, 9'h000, 1'b1, 1'b0, -1);
        rx_l[0] = 1'b0;
        repeat (30 * CPB) @(negedge clock);
        check("break_busy_in_arm", 32'(bsy[0]), 32'd1);
        rx_l[0] = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        push(0, 9'h07E, 1'b0, 1'b0, -1);
        send(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1);

        // Reset in the middle of a frame abandons it
        rx_l[0] = 1'b0;
        repeat (4 * CPB) @(negedge clock);
        reset   = 1'b0;
        rx_l[0] = 1'b1;
        repeat (2) @(negedge clock);
        check("midreset_valid", 32'(vld[0]), 32'd0);
        check("midreset_busy", 32'(bsy[0]), 32'd0);
        check("midreset_data", 32'(md[0]), 32'd0);
        check("midreset_errs", 32'({fe[0], pe[0], ovr[0]}), 32'd0);
        reset = 1'b1;
        repeat (15 * CPB) @(negedge clock);

        check("words_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
